// File: rtl/backend_vertex_bram_writer.sv
// Write stage behind the destination core: buffers vertex writes, drains them into the vertex
// BRAM under a ready handshake and reports when an iteration's writes have all been committed.
module backend_vertex_bram_writer #(
    parameter int V_ID_WIDTH      = 8,
    parameter int V_VALUE_WIDTH   = 32,
    parameter int ITERATION_WIDTH = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int FULL_MARGIN     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [V_ID_WIDTH-1:0]      wr_vertex_bram_addr,
    input  logic [V_VALUE_WIDTH-1:0]   wr_vertex_bram_data,
    input  logic                       wr_vertex_bram_valid,
    input  logic                       wr_vertex_bram_iteration_end,
    input  logic                       wr_vertex_bram_iteration_end_valid,
    input  logic [ITERATION_WIDTH-1:0] wr_vertex_bram_iteration_id,
    input  logic                       bram_wr_ready,
    output logic                       next_stage_full,
    output logic [V_ID_WIDTH-1:0]      bram_wr_addr,
    output logic [V_VALUE_WIDTH-1:0]   bram_wr_data,
    output logic                       bram_wr_en,
    output logic                       iteration_done,
    output logic [ITERATION_WIDTH-1:0] iteration_done_id,
    output logic [V_ID_WIDTH-1:0]      iteration_write_count,
    output logic                       overflow_err,
    output logic                       protocol_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(FIFO_DEPTH - FULL_MARGIN);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    logic [V_ID_WIDTH-1:0]      mem_addr_r [FIFO_DEPTH];
    logic [V_VALUE_WIDTH-1:0]   mem_data_r [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_r;
    logic [PTR_W-1:0]           rd_ptr_r;
    logic [CNT_W-1:0]           count_r;
    logic [CNT_W-1:0]           count_next_s;
    logic                       push_s;
    logic                       pop_s;
    logic                       drop_s;
    logic                       end_req_s;
    state_t                     state_r;
    state_t                     state_next_s;
    logic                       done_next_s;
    logic [ITERATION_WIDTH-1:0] iter_id_r;
    logic [V_ID_WIDTH-1:0]      write_cnt_r;

    // FIFO handshake decode; a pop frees a slot for a push in the same cycle
    always_comb begin
        pop_s     = (count_r != {CNT_W{1'b0}}) && bram_wr_ready;
        end_req_s = wr_vertex_bram_iteration_end && wr_vertex_bram_iteration_end_valid;
        if (wr_vertex_bram_valid && ((count_r < DEPTH_C) || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        drop_s       = wr_vertex_bram_valid && !push_s;
        count_next_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    // FIFO storage carries no reset; validity is tracked by count_r
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_addr_r[wr_ptr_r] <= wr_vertex_bram_addr;
            mem_data_r[wr_ptr_r] <= wr_vertex_bram_data;
        end
    end

    // FIFO pointers, occupancy, BRAM port and backpressure
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r        <= {PTR_W{1'b0}};
            rd_ptr_r        <= {PTR_W{1'b0}};
            count_r         <= {CNT_W{1'b0}};
            bram_wr_en      <= 1'b0;
            bram_wr_addr    <= {V_ID_WIDTH{1'b0}};
            bram_wr_data    <= {V_VALUE_WIDTH{1'b0}};
            next_stage_full <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r     <= rd_ptr_r + PTR_W'(1);
                bram_wr_addr <= mem_addr_r[rd_ptr_r];
                bram_wr_data <= mem_data_r[rd_ptr_r];
            end else begin
                bram_wr_addr <= {V_ID_WIDTH{1'b0}};
                bram_wr_data <= {V_VALUE_WIDTH{1'b0}};
            end
            bram_wr_en      <= pop_s;
            count_r         <= count_next_s;
            next_stage_full <= (count_next_s >= THRESH_C);
        end
    end

    // Iteration FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Iteration FSM next state; DRAIN waits until the last write has left the BRAM port
    always_comb begin
        state_next_s = ST_RUN;
        case (state_r)
            ST_RUN: begin
                if (end_req_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if ((count_r == {CNT_W{1'b0}}) && !bram_wr_en) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_next_s = ST_RUN;
            default:  state_next_s = ST_RUN;
        endcase
    end

    // Iteration FSM output decode, registered below so done lines up with the DONE state
    always_comb begin
        if (state_next_s == ST_DONE) begin
            done_next_s = 1'b1;
        end else begin
            done_next_s = 1'b0;
        end
    end

    // Iteration bookkeeping, completion report and sticky error flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iter_id_r             <= {ITERATION_WIDTH{1'b0}};
            write_cnt_r           <= {V_ID_WIDTH{1'b0}};
            iteration_done        <= 1'b0;
            iteration_done_id     <= {ITERATION_WIDTH{1'b0}};
            iteration_write_count <= {V_ID_WIDTH{1'b0}};
            overflow_err          <= 1'b0;
            protocol_err          <= 1'b0;
        end else begin
            if ((state_r == ST_RUN) && end_req_s) begin
                iter_id_r <= wr_vertex_bram_iteration_id;
            end
            // a commit landing in the clear cycle opens the next iteration's tally
            if (iteration_done) begin
                write_cnt_r <= bram_wr_en ? V_ID_WIDTH'(1) : {V_ID_WIDTH{1'b0}};
            end else if (bram_wr_en && (write_cnt_r != {V_ID_WIDTH{1'b1}})) begin
                write_cnt_r <= write_cnt_r + V_ID_WIDTH'(1);
            end
            iteration_done        <= done_next_s;
            iteration_done_id     <= done_next_s ? iter_id_r : {ITERATION_WIDTH{1'b0}};
            iteration_write_count <= done_next_s ? write_cnt_r : {V_ID_WIDTH{1'b0}};
            if (drop_s) begin
                overflow_err <= 1'b1;
            end
            if (end_req_s && (state_r != ST_RUN)) begin
                protocol_err <= 1'b1;
            end
        end
    end
endmodule
